alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 110 +++++++++++
 tb/tb_alarm_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// alarm_controller: intruder alarm FSM (disarmed/armed/entry countdown/alarm) disarmed by a keypad passcode.
// Build option WRONG_CODE_LOCKOUT_EN: the third wrong code during the entry countdown raises the alarm at once.
package alarm_controller_pkg;
    typedef enum logic [1:0] {STATE_IDLE, STATE_SET, STATE_TRIGGER, STATE_ALERT} fsm_state_t;
endpackage

module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int          CLK_HZ        = 50_000_000,
    parameter int          ENTRY_DELAY_S = 15,
    parameter int          CODE_LEN      = 4,
    parameter logic [31:0] PASSCODE      = 32'h0000_1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm_btn,
    input  logic       enter_btn,
    input  logic [3:0] digit_in,
    input  logic       sensor,
    output fsm_state_t system_state,
    output int         timer,
    output logic [3:0] current_value,
    output logic [3:0] digit_count
);
    localparam int BW = 4 * CODE_LEN;
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;

    fsm_state_t    state_q, state_d;
    int            timer_q, timer_d;
    logic [3:0]    value_q, value_d, count_q, count_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          accept, code_full, code_match, tick, expire, strike_out, changed;

    // Keypad entry decode: shift the new digit in and compare once the code is complete
    always_comb begin
        accept     = enter_btn && state_q != STATE_IDLE;
        buf_d      = accept ? BW'({buf_q, digit_in}) : buf_q;
        code_full  = accept && count_q == 4'(CODE_LEN - 1);
        code_match = code_full && buf_d == PASSCODE[BW-1:0];
        tick       = state_q == STATE_TRIGGER && pre_q == PW'(CLK_HZ - 1);
        expire     = tick && timer_q == 1;
    end

`ifdef WRONG_CODE_LOCKOUT_EN
    logic [1:0] strike_q;
    logic       code_miss;

    assign code_miss  = state_q == STATE_TRIGGER && code_full && !code_match;
    assign strike_out = code_miss && strike_q == 2'd2;

    // Wrong-code strikes during the countdown; progress is forgotten whenever the state moves
    always_ff @(posedge clk) begin
        if (rst || state_d != state_q) strike_q <= 2'd0;
        else if (code_miss)            strike_q <= strike_q + 2'd1;
    end
`else
    assign strike_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= STATE_IDLE;
        else     state_q <= state_d;
    end

    // Next state: a correct code always wins over sensor, expiry and lockout
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE:    state_d = arm_btn ? STATE_SET : STATE_IDLE;
            STATE_SET:     state_d = code_match ? STATE_IDLE : sensor ? STATE_TRIGGER : STATE_SET;
            STATE_TRIGGER: state_d = code_match ? STATE_IDLE : (strike_out || expire) ? STATE_ALERT : STATE_TRIGGER;
            STATE_ALERT:   state_d = code_match ? STATE_IDLE : STATE_ALERT;
            default:       state_d = STATE_IDLE;
        endcase
    end

    // Output/datapath next values: countdown only lives in TRIGGER and restarts on entry
    always_comb begin
        changed = state_d != state_q;
        count_d = (changed || code_full) ? 4'd0 : accept ? count_q + 4'd1 : count_q;
        value_d = accept ? digit_in : value_q;
        pre_d   = (state_d != STATE_TRIGGER || changed || tick) ? '0 : pre_q + 1'b1;
        timer_d = state_d != STATE_TRIGGER ? 0 : changed ? ENTRY_DELAY_S : tick ? timer_q - 1 : timer_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 0;
            value_q <= 4'd0;
            count_q <= 4'd0;
            buf_q   <= '0;
            pre_q   <= '0;
        end else begin
            timer_q <= timer_d;
            value_q <= value_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            pre_q   <= pre_d;
        end
    end

    assign system_state  = state_q;
    assign timer         = timer_q;
    assign current_value = value_q;
    assign digit_count   = count_q;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed and randomized checks of alarm_controller against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_alarm_controller;
    import alarm_controller_pkg::*;

    localparam int          CLK_HZ   = 4;
    localparam int          DELAY    = 3;
    localparam int          CODE_LEN = 4;
    localparam logic [31:0] PASSCODE = 32'h1234;
`ifdef WRONG_CODE_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic clk = 0, rst = 1, arm_btn = 0, enter_btn = 0, sensor = 0;
    logic [3:0] digit_in = 0;
    fsm_state_t system_state;
    int timer;
    logic [3:0] current_value, digit_count;

    logic arm2 = 0, enter2 = 0, sensor2 = 0;
    logic [3:0] digit2 = 0;
    fsm_state_t state2;
    int timer2;
    logic [3:0] value2, count2;

    int n_checks = 0, n_fail = 0;

    fsm_state_t m_st = STATE_IDLE;
    logic [3:0] m_q[$];
    int m_sec = 0, m_el = 0, m_strk = 0;
    logic [3:0] m_cv = 0;

    alarm_controller #(.CLK_HZ(CLK_HZ), .ENTRY_DELAY_S(DELAY), .CODE_LEN(CODE_LEN), .PASSCODE(PASSCODE)) dut (
        .clk(clk), .rst(rst), .arm_btn(arm_btn), .enter_btn(enter_btn), .digit_in(digit_in), .sensor(sensor),
        .system_state(system_state), .timer(timer), .current_value(current_value), .digit_count(digit_count));

    alarm_controller #(.CLK_HZ(CLK_HZ), .ENTRY_DELAY_S(9), .CODE_LEN(CODE_LEN), .PASSCODE(PASSCODE)) dut2 (
        .clk(clk), .rst(rst), .arm_btn(arm2), .enter_btn(enter2), .digit_in(digit2), .sensor(sensor2),
        .system_state(state2), .timer(timer2), .current_value(value2), .digit_count(count2));

    always #5 clk = ~clk;

    function automatic logic [3:0] code_digit(input int i);
        return 4'(PASSCODE >> (4 * (CODE_LEN - 1 - i)));
    endfunction

    task automatic model_edge(input logic a, input logic e, input logic s, input logic r, input logic [3:0] d);
        fsm_state_t ns;
        bit done, match, tick;
        if (r) begin
            m_st = STATE_IDLE; m_q.delete(); m_sec = 0; m_el = 0; m_strk = 0; m_cv = 0;
            return;
        end
        ns = m_st; done = 0; match = 0;
        if (e && m_st != STATE_IDLE) begin
            m_q.push_back(d);
            m_cv = d;
            if (m_q.size() == CODE_LEN) begin
                done = 1; match = 1;
                for (int i = 0; i < CODE_LEN; i++) if (m_q[i] !== code_digit(i)) match = 0;
                m_q.delete();
            end
        end
        tick = m_st == STATE_TRIGGER && (m_el + 1) % CLK_HZ == 0;
        if (m_st == STATE_TRIGGER) m_el++;
        case (m_st)
            STATE_IDLE: if (a) ns = STATE_SET;
            STATE_SET: begin
                if (match) ns = STATE_IDLE;
                else if (s) begin ns = STATE_TRIGGER; m_sec = DELAY; end
            end
            STATE_TRIGGER: begin
                if (match) ns = STATE_IDLE;
                else begin
                    if (done) m_strk++;
                    if (LOCKOUT && m_strk == 3) ns = STATE_ALERT;
                    else if (tick) begin
                        m_sec--;
                        if (m_sec == 0) ns = STATE_ALERT;
                    end
                end
            end
            default: if (match) ns = STATE_IDLE;
        endcase
        if (ns != m_st) begin m_q.delete(); m_strk = 0; m_el = 0; end
        if (ns != STATE_TRIGGER) m_sec = 0;
        m_st = ns;
    endtask

    task automatic step(input logic a, input logic e, input logic s, input logic r, input logic [3:0] d);
        @(negedge clk);
        arm_btn = a; enter_btn = e; sensor = s; rst = r; digit_in = d;
        @(posedge clk);
        model_edge(a, e, s, r, d);
        #1;
    endtask

    task automatic test_reset;
        step(1, 1, 1, 1, 4'h9);
        step(0, 0, 0, 1, 4'h0);
        n_checks++;
        if (system_state !== STATE_IDLE || timer !== 0 || current_value !== 4'd0 || digit_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: got state=%0d timer=%0d cv=%0d dc=%0d, want 0 0 0 0", system_state, timer, current_value, digit_count);
        end
    endtask

    task automatic test_arm_disarm;
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 4'h1);
        n_checks++;
        if (system_state !== STATE_IDLE || current_value !== 4'd0 || digit_count !== 4'd0) begin
            n_fail++;
            $display("FAIL enter_in_idle: got state=%0d cv=%0d dc=%0d, want IDLE 0 0", system_state, current_value, digit_count);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (system_state !== STATE_SET || timer !== 0) begin
            n_fail++;
            $display("FAIL arm: got state=%0d timer=%0d, want SET 0", system_state, timer);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, code_digit(i));
        n_checks++;
        if (system_state !== STATE_SET || digit_count !== 4'd3 || current_value !== 4'd3) begin
            n_fail++;
            $display("FAIL set_entry: got state=%0d dc=%0d cv=%0d, want SET 3 3", system_state, digit_count, current_value);
        end
        step(1, 1, 0, 0, code_digit(3));
        n_checks++;
        if (system_state !== STATE_IDLE || timer !== 0 || digit_count !== 4'd0 || current_value !== 4'd4) begin
            n_fail++;
            $display("FAIL disarm: got state=%0d timer=%0d dc=%0d cv=%0d, want IDLE 0 0 4", system_state, timer, digit_count, current_value);
        end
    endtask

    task automatic test_countdown;
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        n_checks++;
        if (system_state !== STATE_TRIGGER || timer !== 3) begin
            n_fail++;
            $display("FAIL trigger_entry: got state=%0d timer=%0d, want TRIGGER 3", system_state, timer);
        end
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 1, 0, 0);
            if (k % 4 == 0) begin
                n_checks++;
                if (system_state !== (k == 12 ? STATE_ALERT : STATE_TRIGGER) || timer !== 3 - k / 4) begin
                    n_fail++;
                    $display("FAIL countdown_%0d: got state=%0d timer=%0d, want timer=%0d", k, system_state, timer, 3 - k / 4);
                end
            end
        end
        for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 0);
        n_checks++;
        if (system_state !== STATE_ALERT || timer !== 0) begin
            n_fail++;
            $display("FAIL alert_hold: got state=%0d timer=%0d, want ALERT 0", system_state, timer);
        end
    endtask

    task automatic test_wrong_right;
        logic [3:0] seq [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h1, 4'h2, 4'h3, 4'h4};
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, seq[i]);
            n_checks++;
            if (system_state !== m_st || timer !== m_sec || current_value !== seq[i] || digit_count !== 4'(m_q.size())) begin
                n_fail++;
                $display("FAIL wrong_right_%0d: got state=%0d timer=%0d cv=%0d dc=%0d, want %0d %0d %0d %0d",
                         i, system_state, timer, current_value, digit_count, m_st, m_sec, seq[i], m_q.size());
            end
            if (i == 3) begin
                n_checks++;
                if (system_state !== STATE_TRIGGER || digit_count !== 4'd0) begin
                    n_fail++;
                    $display("FAIL wrong_code: got state=%0d dc=%0d, want TRIGGER 0", system_state, digit_count);
                end
            end
        end
        n_checks++;
        if (system_state !== STATE_IDLE || timer !== 0) begin
            n_fail++;
            $display("FAIL right_code: got state=%0d timer=%0d, want IDLE 0", system_state, timer);
        end
    endtask

    task automatic test_race;
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, code_digit(i));
        n_checks++;
        if (system_state !== STATE_TRIGGER || timer !== 1) begin
            n_fail++;
            $display("FAIL race_pre: got state=%0d timer=%0d, want TRIGGER 1", system_state, timer);
        end
        step(0, 1, 0, 0, code_digit(3));
        n_checks++;
        if (system_state !== STATE_IDLE || timer !== 0) begin
            n_fail++;
            $display("FAIL race_expiry: got state=%0d timer=%0d, want IDLE 0", system_state, timer);
        end
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, code_digit(i));
        step(0, 1, 1, 0, code_digit(3));
        n_checks++;
        if (system_state !== STATE_IDLE || timer !== 0 || digit_count !== 4'd0) begin
            n_fail++;
            $display("FAIL race_sensor: got state=%0d timer=%0d dc=%0d, want IDLE 0 0", system_state, timer, digit_count);
        end
    endtask

    task automatic test_reset_mid;
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4'h7);
        step(0, 1, 0, 0, 4'h8);
        n_checks++;
        if (system_state !== STATE_TRIGGER || timer !== 2 || digit_count !== 4'd2) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got state=%0d timer=%0d dc=%0d, want TRIGGER 2 2", system_state, timer, digit_count);
        end
        step(1, 1, 1, 1, 4'h9);
        n_checks++;
        if (system_state !== STATE_IDLE || timer !== 0 || current_value !== 4'd0 || digit_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got state=%0d timer=%0d cv=%0d dc=%0d, want 0 0 0 0", system_state, timer, current_value, digit_count);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (system_state !== STATE_SET) begin
            n_fail++;
            $display("FAIL first_after_reset: got state=%0d, want SET", system_state);
        end
    endtask

    task automatic test_lockout;
        logic [3:0] bad [4] = '{4'h1, 4'h2, 4'h3, 4'h5};
        step(0, 0, 0, 1, 0);
        @(negedge clk); rst = 0; arm2 = 1;
        @(negedge clk); arm2 = 0; sensor2 = 1;
        @(negedge clk); sensor2 = 0;
        for (int i = 0; i < 12; i++) begin
            enter2 = 1; digit2 = bad[i % 4];
            @(posedge clk); #1;
            if (i == 7) begin
                n_checks++;
                if (state2 !== STATE_TRIGGER || timer2 !== 7 || count2 !== 4'd0) begin
                    n_fail++;
                    $display("FAIL lockout_two: got state=%0d timer=%0d dc=%0d, want TRIGGER 7 0", state2, timer2, count2);
                end
            end
            @(negedge clk);
        end
        enter2 = 0;
        n_checks++;
        if (state2 !== (LOCKOUT ? STATE_ALERT : STATE_TRIGGER) || timer2 !== (LOCKOUT ? 0 : 6)) begin
            n_fail++;
            $display("FAIL lockout_three: got state=%0d timer=%0d, want state=%0d timer=%0d",
                     state2, timer2, LOCKOUT ? STATE_ALERT : STATE_TRIGGER, LOCKOUT ? 0 : 6);
        end
    endtask

    task automatic test_random;
        logic a, e, s, r;
        logic [3:0] d;
        step(0, 0, 0, 1, 0);
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 199) == 0;
            a = $urandom_range(0, 7) == 0;
            s = $urandom_range(0, 5) == 0;
            e = $urandom_range(0, 1) == 1;
            d = $urandom_range(0, 9) < 6 ? code_digit(m_q.size()) : 4'($urandom_range(0, 15));
            step(a, e, s, r, d);
            n_checks++;
            if ({system_state, timer, current_value, digit_count} !== {m_st, m_sec, m_cv, 4'(m_q.size())}) begin
                n_fail++;
                $display("FAIL random_%0d: got state=%0d timer=%0d cv=%0d dc=%0d, want %0d %0d %0d %0d",
                         c, system_state, timer, current_value, digit_count, m_st, m_sec, m_cv, m_q.size());
            end
        end
    endtask

    initial begin
        test_reset;
        test_arm_disarm;
        test_countdown;
        test_wrong_right;
        test_race;
        test_reset_mid;
        test_lockout;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
